regfile_access_ctrl: RTL
========================

# regfile_access_ctrl

Synchronous front-end sequencer for the variable-size register file. It accepts single-word read and write requests from a host over a req/ack handshake. It generates the file's chip-select, output-enable and write-strobe signals with guaranteed setup and hold around each write. It owns the bidirectional data bus and captures read data into a host-side register.

## Interface

Parameters:
- Width, 8, data word width in bits; must match the register file.
- Depth, 4, address width in bits; the register file holds 2**Depth words.

Ports:
- clk_i  input  1  single clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  1  host request; sampled only in IDLE.
- we_i  input  1  1 = write, 0 = read; sampled with req_i.
- addr_i  input  Depth  host address; sampled with req_i.
- wdata_i  input  Width  host write data; sampled with req_i.
- ack_o  output  1  one-cycle completion pulse.
- busy_o  output  1  high in every state other than IDLE.
- rdata_o  output  Width  last captured read data.
- mem_cs_no  output  1  register-file chip select, active-low.
- mem_oe_o  output  1  register-file output enable; 1 means the file drives the bus.
- mem_ws_o  output  1  register-file write strobe; the file writes on its rising edge.
- mem_addr_o  output  Depth  register-file address.
- mem_data_io  inout  Width  shared data bus.

## Operation

- FSM states: IDLE, WSETUP, WSTROBE, WHOLD, RSETUP, RCAPTURE, DONE.
- IDLE:
  - If req_i=1 at a clock edge, latch we_i, addr_i and wdata_i into internal registers.
  - Go to WSETUP if we_i=1, otherwise to RSETUP.
  - If req_i=0, stay in IDLE.
- Write path, WSETUP → WSTROBE → WHOLD → DONE:
  - cs_n=0 and oe=0 in all three write states.
  - mem_ws_o=1 only in WSTROBE.
  - Controller drives mem_data_io with the latched data in all three write states.
- Read path, RSETUP → RCAPTURE → DONE:
  - cs_n=0 and oe=1 in both read states.
  - Controller drives mem_data_io to high-Z.
  - rdata_o loads mem_data_io on the edge that leaves RCAPTURE.
- DONE:
  - ack_o=1, cs_n=1, oe=0, ws=0, bus high-Z.
  - Unconditionally returns to IDLE on the next edge.
- IDLE outputs: cs_n=1, oe=0, ws=0, bus high-Z.
- Output decoding:
  - All mem_* strobes and ack_o are decoded from registered state only (Moore); no combinational path from req_i.
  - mem_addr_o always presents the latched address.
- Operand stability: host inputs other than req_i are don't-care outside the acceptance edge. Changing them while busy has no effect.
- Ignored requests: req_i while busy_o=1, including during DONE, is ignored and not queued. The host must hold or reissue req_i until it is sampled in IDLE.
- rdata_o is unchanged by writes and holds its value until the next read capture.

## Timing

- Edge E0 is the edge that accepts the request in IDLE.
- Write latency:
  - WSETUP after E0, WSTROBE after E1, WHOLD after E2, DONE after E3 (ack_o high), IDLE after E4.
  - ws rises one full cycle after cs_n/data become valid (setup) and falls one cycle before cs_n deasserts (hold).
- Read latency:
  - RSETUP after E0, RCAPTURE after E1.
  - rdata_o valid from E2 onward, in the same cycle ack_o is high (DONE).
  - IDLE after E3.
- Throughput: at most one write per 5 cycles and one read per 4 cycles.
- Bus turnaround: DONE and IDLE tristate the controller's bus driver and deassert cs_n. The controller and the register file never drive the bus simultaneously.
- Asynchronous reset (including mid-operation):
  - Forces IDLE immediately, without waiting for a clock edge.
  - Output values: ack_o=0, busy_o=0, rdata_o=0, mem_cs_no=1, mem_oe_o=0, mem_ws_o=0, mem_addr_o=0, bus high-Z.
  - Latched operands clear to 0.
  - A reset during WSTROBE may leave the target word written. No ack is issued for the aborted transaction.
- First request is accepted on the first rising edge after rst_i deasserts.

## Test plan

- Reset: assert rst_i mid-cycle with no clock -> all outputs reach their reset values immediately and mem_data_io reads Z.
- Write then read: write 0xA5 to address 3, then read address 3 -> ack on the 4th cycle after write acceptance, ws high for exactly one cycle, rdata_o=0xA5 with ack on the 3rd cycle after read acceptance.
- Full sweep: write addr^0x5A to all 16 addresses, then read them back -> every read matches, and cs_n is never low in IDLE or DONE.
- Busy rejection: pulse req_i with a write to address 1 during WSTROBE of a write to address 0 -> only address 0 is written and exactly one ack pulse occurs.
- Operand stability: change addr_i and wdata_i every cycle after acceptance -> the write uses the E0 values and mem_addr_o stays constant throughout.
- Reset mid-read: assert rst_i in RCAPTURE -> no ack, rdata_o=0, and the next read after reset completes normally.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Host-side sequencer for the register file: turns req/ack single-word reads and writes into
// cs_n / oe / ws strobes with one cycle of setup and hold around the write strobe.
module regfile_access_ctrl #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [Depth-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic             ack_o,
  output logic             busy_o,
  output logic [Width-1:0] rdata_o,
  output logic             mem_cs_no,
  output logic             mem_oe_o,
  output logic             mem_ws_o,
  output logic [Depth-1:0] mem_addr_o,
  inout  wire  [Width-1:0] mem_data_io
);

  typedef enum logic [2:0] {
    StIdle,
    StWSetup,
    StWStrobe,
    StWHold,
    StRSetup,
    StRCapture,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [Depth-1:0] addr_q;
  logic [Width-1:0] wdata_q;
  logic [Width-1:0] rdata_q;
  logic             accept;
  logic             drive_bus;

  assign accept = (state_q == StIdle) && req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands are captured only on the accepting edge so host changes while busy are ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (state_q == StRCapture) begin
      rdata_q <= mem_data_io;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = we_i ? StWSetup : StRSetup;
        end
      end
      StWSetup:   state_d = StWStrobe;
      StWStrobe:  state_d = StWHold;
      StWHold:    state_d = StDone;
      StRSetup:   state_d = StRCapture;
      StRCapture: state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    ack_o     = 1'b0;
    busy_o    = 1'b1;
    mem_cs_no = 1'b1;
    mem_oe_o  = 1'b0;
    mem_ws_o  = 1'b0;
    drive_bus = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_o = 1'b0;
      end
      StWSetup, StWHold: begin
        mem_cs_no = 1'b0;
        drive_bus = 1'b1;
      end
      StWStrobe: begin
        mem_cs_no = 1'b0;
        mem_ws_o  = 1'b1;
        drive_bus = 1'b1;
      end
      StRSetup, StRCapture: begin
        mem_cs_no = 1'b0;
        mem_oe_o  = 1'b1;
      end
      StDone: begin
        ack_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign rdata_o     = rdata_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_io = drive_bus ? wdata_q : {Width{1'bz}};

endmodule
